// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR signature monitor.
package misr_pkg;

  // Run sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    CHECK,
    DONE
  } misr_state_t;

  // x^64 + x^4 + x^3 + x + 1 feedback taps (x^64 term implied).
  localparam logic [63:0] DEFAULT_POLY64 = 64'h0000_0000_0000_001B;

endpackage

// File: rtl/misr_lane.sv
// One MISR channel: shift-left Galois register folded with the channel input.
//   clk  : clock
//   clr  : load SEED (highest priority)
//   en   : perform one compaction step
//   din  : channel input, zero-extended to SIG_W
//   sig  : current signature
module misr_lane
  import misr_pkg::*;
#(
  parameter int unsigned       SIG_W = 64,
  parameter int unsigned       IN_W  = 64,
  parameter logic [SIG_W-1:0]  POLY  = SIG_W'(DEFAULT_POLY64),
  parameter logic [SIG_W-1:0]  SEED  = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  // Multiply by x modulo the feedback polynomial, then add the input word.
  always_ff @(posedge clk) begin
    if (clr) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
    end
  end

endmodule

// File: rtl/misr_sig_monitor.sv
// N-channel MISR signature monitor: sequences MISR reset, a fixed compaction
// window and a golden-signature compare, and tracks QED consistency.
//   clk, rst        : clock, synchronous active-high reset
//   ena             : compaction enable (0 stalls counter and MISRs)
//   start           : begin a run; aborts a run in progress
//   cont_mode       : restart automatically after each CHECK
//   qed_consistent  : QED register copies agree this cycle
//   data_in         : channel c at [c*IN_W +: IN_W]
//   golden_sig      : expected signatures, sampled in CHECK
//   misr_reset      : high during the RESET cycle
//   busy / done     : run in progress / results held
//   pass            : no mismatch and no inconsistency (valid with done)
//   mismatch_mask   : per-channel signature mismatch from last CHECK
//   incons_seen     : sticky inconsistency flag for the current run
//   win_cnt         : compactions done in current run
//   sig_out         : live signatures
module misr_sig_monitor
  import misr_pkg::*;
#(
  parameter int unsigned      NUM_CH = 8,
  parameter int unsigned      IN_W   = 64,
  parameter int unsigned      SIG_W  = 64,
  parameter int unsigned      WINDOW = 124,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY64),
  parameter logic [SIG_W-1:0] SEED   = '0,
  localparam int unsigned     CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    start,
  input  logic                    cont_mode,
  input  logic                    qed_consistent,
  input  logic [NUM_CH*IN_W-1:0]  data_in,
  input  logic [NUM_CH*SIG_W-1:0] golden_sig,
  output logic                    misr_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_CH-1:0]       mismatch_mask,
  output logic                    incons_seen,
  output logic [CNT_W-1:0]        win_cnt,
  output logic [NUM_CH*SIG_W-1:0] sig_out
);

  misr_state_t       state;
  logic              enter_reset;
  logic              lane_clr;
  logic              lane_en;
  logic [NUM_CH-1:0] cmp;

  // Any start restarts the run; cont_mode restarts from CHECK or DONE.
  assign enter_reset = start | (cont_mode & ((state == CHECK) | (state == DONE)));
  assign lane_clr    = rst | (state == RESET);
  assign lane_en     = (state == RUN) & ena;

  // Per-channel compare against golden values.
  always_comb begin
    cmp = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cmp[c] = sig_out[c*SIG_W +: SIG_W] != golden_sig[c*SIG_W +: SIG_W];
    end
  end

  // Sequencer, window counter, sticky consistency flag and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      misr_reset    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= '0;
      incons_seen   <= 1'b0;
      win_cnt       <= '0;
    end else begin
      misr_reset <= enter_reset;

      // Results register in CHECK unless the run is being aborted.
      if ((state == CHECK) && !start) begin
        mismatch_mask <= cmp;
        pass          <= (cmp == '0) && !incons_seen;
      end

      if (enter_reset) begin
        // Counter reads 0 already in the RESET cycle, including on abort.
        state       <= RESET;
        busy        <= 1'b1;
        done        <= 1'b0;
        win_cnt     <= '0;
        incons_seen <= 1'b0;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          RESET: state <= RUN;
          RUN: begin
            if (ena) begin
              win_cnt     <= win_cnt + CNT_W'(1);
              incons_seen <= incons_seen | ~qed_consistent;
              if (win_cnt == CNT_W'(WINDOW - 1)) state <= CHECK;
            end
          end
          CHECK: begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    misr_lane #(
      .SIG_W (SIG_W),
      .IN_W  (IN_W),
      .POLY  (POLY),
      .SEED  (SEED)
    ) u_lane (
      .clk (clk),
      .clr (lane_clr),
      .en  (lane_en),
      .din (data_in[c*IN_W +: IN_W]),
      .sig (sig_out[c*SIG_W +: SIG_W])
    );
  end

endmodule

// File: tb/tb_misr_sig_monitor.sv
// Scoreboard bench for misr_sig_monitor (2 channels, 8-bit, window 4, poly 0x1D).
module tb_misr_sig_monitor;

  localparam int NUM_CH = 2;
  localparam int IN_W   = 8;
  localparam int SIG_W  = 8;
  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  localparam int M_RAND = 0, M_ZERO = 1, M_ONES = 2, M_FEED = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    ena = 1'b0;
  logic                    start = 1'b0;
  logic                    cont_mode = 1'b0;
  logic                    qed_consistent = 1'b1;
  logic [NUM_CH*IN_W-1:0]  data_in = '0;
  logic [NUM_CH*SIG_W-1:0] golden_sig = '0;
  logic                    misr_reset, busy, done, pass, incons_seen;
  logic [NUM_CH-1:0]       mismatch_mask;
  logic [CNT_W-1:0]        win_cnt;
  logic [NUM_CH*SIG_W-1:0] sig_out;

  misr_sig_monitor #(
    .NUM_CH (NUM_CH),
    .IN_W   (IN_W),
    .SIG_W  (SIG_W),
    .WINDOW (WINDOW),
    .POLY   (8'h1D),
    .SEED   (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .start          (start),
    .cont_mode      (cont_mode),
    .qed_consistent (qed_consistent),
    .data_in        (data_in),
    .golden_sig     (golden_sig),
    .misr_reset     (misr_reset),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_mask  (mismatch_mask),
    .incons_seen    (incons_seen),
    .win_cnt        (win_cnt),
    .sig_out        (sig_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  mask;
    logic        pass;
    logic        incons;
    logic [15:0] sigs;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Signature arithmetic: multiply by x modulo x^8+x^4+x^3+x^2+1, then add data.
  function automatic logic [7:0] gf_step(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] p;
    p = {s, 1'b0};
    if (p[8]) p = p ^ 9'h11D;
    return p[7:0] ^ d;
  endfunction

  // Monitor: every rising done is matched against the oldest expected run.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_done: got done=1 required no pending run (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_mask",   64'(mismatch_mask), 64'(e.mask));
        check("sb_pass",   64'(pass),          64'(e.pass));
        check("sb_incons", 64'(incons_seen),   64'(e.incons));
        check("sb_sigs",   64'(sig_out),       64'(e.sigs));
        check("sb_done_cycle", 64'(cyc),       64'(e.done_cyc));
      end
    end
    done_q = done;
  end

  // One complete run. stall_at: compaction index before which ena drops 3 cycles
  // (qed_consistent low while stalled); bad_qed: drop qed on an enabled cycle.
  task automatic do_run(input int mode, input int stall_at, input bit bad_qed);
    logic [7:0] m0, m1, d0, d1, g0, g1;
    logic       en, qd, inc;
    int         n, stalls, c0;
    exp_t       e;
    bit         seen;
    @(negedge clk);
    start = 1'b1; ena = 1'b1; qed_consistent = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("run_misr_reset_pulse", 64'(misr_reset), 64'(1));
    check("run_busy_in_reset",    64'(busy),       64'(1));
    m0 = 8'h00; m1 = 8'h00; inc = 1'b0; n = 0; stalls = 0;
    while (n < WINDOW) begin
      @(negedge clk);
      en = 1'b1; qd = 1'b1;
      d0 = 8'($urandom); d1 = 8'($urandom);
      case (mode)
        M_ZERO: begin d0 = 8'h00; d1 = 8'h00; end
        M_ONES: begin d0 = 8'h01; d1 = 8'h00; end
        M_FEED: begin d0 = (n == WINDOW - 2) ? 8'h80 : 8'h00; d1 = 8'h00; end
        default: begin
          en = ($urandom_range(0, 3) != 0);
          qd = ($urandom_range(0, 7) != 0);
        end
      endcase
      if (stall_at == n && stalls < 3) begin en = 1'b0; qd = 1'b0; end
      if (bad_qed && n == 1 && en) qd = 1'b0;
      ena = en; qed_consistent = qd; data_in = {d1, d0};
      if (en) begin
        m0 = gf_step(m0, d0);
        m1 = gf_step(m1, d1);
        inc = inc | ~qd;
        n++;
      end else begin
        stalls++;
      end
    end
    case (mode)
      M_ZERO:  begin g0 = 8'h00; g1 = 8'h00; end
      M_ONES:  begin g0 = 8'h0F; g1 = 8'h00; end
      M_FEED:  begin g0 = 8'h00; g1 = 8'h00; end
      default: begin
        g0 = ($urandom_range(0, 1) != 0) ? m0 : m0 ^ 8'($urandom_range(1, 255));
        g1 = ($urandom_range(0, 1) != 0) ? m1 : m1 ^ 8'($urandom_range(1, 255));
      end
    endcase
    golden_sig = {g1, g0};
    e.mask     = {m1 != g1, m0 != g0};
    e.pass     = (e.mask == 2'b00) && !inc;
    e.incons   = inc;
    e.sigs     = {m1, m0};
    e.done_cyc = c0 + WINDOW + 3 + stalls;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      ena = 1'b0;
      seen = done;
    end
    if (!seen) begin
      checks++;
      $display("FAIL run_done_timeout: got done=0 required done=1 (cycle %0d)", cyc);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  int pulses[$];
  bit hit;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_misr_reset", 64'(misr_reset),    64'(0));
    check("rst_busy",       64'(busy),          64'(0));
    check("rst_done",       64'(done),          64'(0));
    check("rst_pass",       64'(pass),          64'(0));
    check("rst_mask",       64'(mismatch_mask), 64'(0));
    check("rst_incons",     64'(incons_seen),   64'(0));
    check("rst_win_cnt",    64'(win_cnt),       64'(0));
    check("rst_sig_out",    64'(sig_out),       64'(0));
    rst = 1'b0;

    do_run(M_ZERO, -1, 1'b0);
    do_run(M_ONES, -1, 1'b0);
    do_run(M_FEED, -1, 1'b0);
    do_run(M_ZERO,  2, 1'b0);
    do_run(M_ZERO, -1, 1'b1);
    for (int r = 0; r < 16; r++) do_run(M_RAND, -1, 1'b0);

    // Abort at win_cnt == 2.
    @(negedge clk);
    start = 1'b1; ena = 1'b1; qed_consistent = 1'b1; data_in = 16'hA55A;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = (win_cnt == CNT_W'(2));
    end
    check("abort_reached_cnt2", 64'(hit), 64'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_misr_reset", 64'(misr_reset), 64'(1));
    check("abort_win_cnt",    64'(win_cnt),    64'(0));
    check("abort_done",       64'(done),       64'(0));

    // rst in RUN (with start) returns to IDLE with everything cleared.
    repeat (3) @(negedge clk);
    check("run_sig_nonzero", 64'(sig_out != '0), 64'(1));
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rstrun_misr_reset", 64'(misr_reset),    64'(0));
    check("rstrun_busy",       64'(busy),          64'(0));
    check("rstrun_win_cnt",    64'(win_cnt),       64'(0));
    check("rstrun_sig_out",    64'(sig_out),       64'(0));
    check("rstrun_mask",       64'(mismatch_mask), 64'(0));
    check("rstrun_pass",       64'(pass),          64'(0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rstrun_idle_busy", 64'(busy), 64'(0));

    // Continuous mode: periodic misr_reset, done never raised.
    cont_mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      data_in = 16'($urandom);
      if (misr_reset) pulses.push_back(cyc);
      if (done) hit = 1'b1;
      @(negedge clk);
    end
    check("cont_done_never", 64'(hit), 64'(0));
    check("cont_pulse_count", 64'(pulses.size() >= 6), 64'(1));
    for (int i = 1; i < pulses.size(); i++)
      check("cont_pulse_period", 64'(pulses[i] - pulses[i-1]), 64'(WINDOW + 2));
    rst = 1'b1; cont_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("sb_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
